// File: rtl/alarm_clock_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alarm_clock_pkg
// Description : Shared types and constants for the alarm-clock button path:
//               debounce state encoding, default timing constants and
//               button channel index names.
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_clock_pkg;

  // Debounce FSM state width and encoding
  localparam int unsigned DB_STATE_W = 2;

  typedef enum logic [DB_STATE_W-1:0] {
    DB_IDLE   = 2'd0,  // stable released, level 0
    DB_CHK_HI = 2'd1,  // candidate press being qualified, level 0
    DB_HELD   = 2'd2,  // stable pressed, level 1
    DB_CHK_LO = 2'd3   // candidate release being qualified, level 1
  } db_state_e;

  // Default timing at 100 MHz
  localparam int unsigned DEF_NUM_BTNS     = 5;
  localparam int unsigned DEF_DB_CYCLES    = 1000000;   // 10 ms
  localparam int unsigned DEF_CNT_W        = 20;
  localparam int unsigned DEF_REPEAT_DELAY = 50000000;  // 500 ms
  localparam int unsigned DEF_REPEAT_RATE  = 20000000;  // 200 ms

  // Button channel indices on the btn_* vectors
  localparam int unsigned BTN_SET    = 0;
  localparam int unsigned BTN_HR     = 1;
  localparam int unsigned BTN_MIN    = 2;
  localparam int unsigned BTN_ALARM  = 3;
  localparam int unsigned BTN_SNOOZE = 4;

  // Debounced level implied by a state: 1 while pressed or qualifying release
  function automatic logic db_state_is_high(input db_state_e s);
    return (s == DB_HELD) || (s == DB_CHK_LO);
  endfunction

endpackage : alarm_clock_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : Single-button debouncer. A four-state FSM qualifies each
//               level change over DB_CYCLES consecutive samples and emits a
//               registered level plus one-cycle press/release pulses.
//               Optional macro AUTOREPEAT_EN adds a hold-to-repeat timer that
//               re-pulses press while the button stays down.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
  import alarm_clock_pkg::*;
#(
  parameter int unsigned DB_CYCLES    = DEF_DB_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W
`ifdef AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;

  // Qualification complete on this edge (stable for DB_CYCLES samples)
  logic w_accept_hi;
  logic w_accept_lo;
  logic w_repeat_fire;

  assign w_accept_hi = (state_q == DB_CHK_HI) &&  btn_i && (cnt_q == CNT_LAST);
  assign w_accept_lo = (state_q == DB_CHK_LO) && !btn_i && (cnt_q == CNT_LAST);

  // State and qualification counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: any disagreeing sample aborts a qualification and returns
  // to the stable state; the counter is reloaded on every transition so it
  // can never run past DB_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DB_IDLE: begin
        if (btn_i) begin
          state_d = DB_CHK_HI;
          cnt_d   = CNT_ONE;
        end
      end
      DB_CHK_HI: begin
        if (!btn_i) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DB_HELD: begin
        if (!btn_i) begin
          state_d = DB_CHK_LO;
          cnt_d   = CNT_ONE;
        end
      end
      DB_CHK_LO: begin
        if (btn_i) begin
          state_d = DB_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef AUTOREPEAT_EN
  // Repeat timer sized for the longer of the two repeat intervals
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX) + 1;

  localparam logic [RPT_W-1:0] RPT_ONE        = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_FIRST_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT_LAST  = RPT_W'(REPEAT_RATE - 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_phase_q, rpt_phase_d;  // 0: waiting first repeat, 1: periodic
  logic             w_rpt_active;
  logic             w_rpt_hit;

  // Timer only runs while the debounced level is high; a CHK_LO->HELD bounce
  // keeps it running because state_q stays in the high pair.
  assign w_rpt_active = db_state_is_high(state_q);
  assign w_rpt_hit    = w_rpt_active &&
                        (rpt_cnt_q == (rpt_phase_q ? RPT_NEXT_LAST : RPT_FIRST_LAST));
  // An accepted release on the same edge suppresses the repeat pulse
  assign w_repeat_fire = w_rpt_hit && !w_accept_lo;

  // Repeat timer next state: restart on accepted press, reload after each hit
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_phase_d = rpt_phase_q;
    if (w_accept_hi) begin
      rpt_cnt_d   = '0;
      rpt_phase_d = 1'b0;
    end else if (w_rpt_active) begin
      if (w_rpt_hit) begin
        rpt_cnt_d   = '0;
        rpt_phase_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_ONE;
      end
    end
  end

  // Repeat timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end
`else
  assign w_repeat_fire = 1'b0;
`endif

  // Output decode: level follows the next state, pulses mark accepted edges
  always_comb begin
    level_d   = db_state_is_high(state_d);
    press_d   = w_accept_hi | w_repeat_fire;
    release_d = w_accept_lo;
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : NUM_BTNS independent button debouncers for the alarm clock.
//               Inputs are already synchronized; outputs are a debounced
//               level and one-cycle press/release pulses per button.
//               Optional macro AUTOREPEAT_EN enables hold-to-repeat press
//               pulses after REPEAT_DELAY, then every REPEAT_RATE cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
  import alarm_clock_pkg::*;
#(
  parameter int unsigned NUM_BTNS     = DEF_NUM_BTNS,
  parameter int unsigned DB_CYCLES    = DEF_DB_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_sync,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release
);

  // Elaboration-time sanity checks on the timing parameters
  if (DB_CYCLES < 2) begin : g_bad_db_cycles
    $error("button_debouncer: DB_CYCLES must be at least 2");
  end
  if ((64'd1 << CNT_W) <= 64'(DB_CYCLES)) begin : g_bad_cnt_w
    $error("button_debouncer: CNT_W too narrow for DB_CYCLES");
  end
  if ((REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_bad_repeat
    $error("button_debouncer: REPEAT_DELAY and REPEAT_RATE must be nonzero");
  end

  // One fully independent debouncer per button
  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
    debounce_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .CNT_W        (CNT_W)
`ifdef AUTOREPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
`endif
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_i     (btn_sync[gi]),
      .level_o   (btn_level[gi]),
      .press_o   (btn_press[gi]),
      .release_o (btn_release[gi])
    );
  end

endmodule : button_debouncer
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debouncer
// Description : Self-checking bench for button_debouncer with DB_CYCLES=8,
//               REPEAT_DELAY=16, REPEAT_RATE=4. Expected results follow
//               AUTOREPEAT_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

  localparam int NB = 5;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_sync = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  typedef struct {
    logic [NB-1:0] btn;
    logic [NB-1:0] lvl;
    logic [NB-1:0] pr;
    logic [NB-1:0] rl;
  } vec_t;

  vec_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  button_debouncer #(
    .NUM_BTNS     (NB),
    .DB_CYCLES    (8),
    .CNT_W        (5),
    .REPEAT_DELAY (16),
    .REPEAT_RATE  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_sync    (btn_sync),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  function automatic logic [NB-1:0] on(input int ch, input bit v);
    return v ? (NB'(1) << ch) : '0;
  endfunction

  task automatic check(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge
  task automatic cyc(input logic [NB-1:0] b, input logic [NB-1:0] lvl,
                     input logic [NB-1:0] pr, input logic [NB-1:0] rl,
                     input string nm, input int k);
    vec_t v;
    vec_t e;
    btn_sync = b;
    v.btn = b; v.lvl = lvl; v.pr = pr; v.rl = rl;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check($sformatf("%s@%0d level",   nm, k), btn_level,   e.lvl);
    check($sformatf("%s@%0d press",   nm, k), btn_press,   e.pr);
    check($sformatf("%s@%0d release", nm, k), btn_release, e.rl);
  endtask

  // Hold reset for two edges with the given buttons, check outputs cleared
  task automatic do_reset(input logic [NB-1:0] b, input string nm);
    rst_n    = 1'b0;
    btn_sync = b;
    repeat (2) @(posedge clk);
    #1;
    check({nm, " rst level"},   btn_level,   '0);
    check({nm, " rst press"},   btn_press,   '0);
    check({nm, " rst release"}, btn_release, '0);
    rst_n = 1'b1;
  endtask

  vec_t tbl[20];
  int   rep_edges[$];

  initial begin
    // 1: all buttons held through reset, accepted together 8 edges after
    do_reset(5'b11111, "t1");
    for (int k = 1; k <= 9; k++)
      cyc(5'b11111, (k >= 8) ? 5'b11111 : 5'b00000, (k == 8) ? 5'b11111 : 5'b00000,
          5'b00000, "t1", k);

    // 2: table-driven single press on channel 0
    for (int i = 0; i < 20; i++) begin
      tbl[i].btn = 5'b00001;
      tbl[i].lvl = on(0, (i + 1) >= 8);
      tbl[i].pr  = on(0, (i + 1) == 8);
      tbl[i].rl  = 5'b00000;
    end
    do_reset(5'b00000, "t2");
    for (int i = 0; i < 20; i++)
      cyc(tbl[i].btn, tbl[i].lvl, tbl[i].pr, tbl[i].rl, "t2", i + 1);

    // 3: channel 1 bounces every 3 cycles, then settles high
    do_reset(5'b00000, "t3");
    for (int k = 1; k <= 30; k++)
      cyc(on(1, (((k - 1) / 3) % 2) == 0), 5'b0, 5'b0, 5'b0, "t3 bounce", k);
    for (int k = 1; k <= 9; k++)
      cyc(on(1, 1'b1), on(1, k >= 8), on(1, k == 8), 5'b0, "t3 settle", k);

    // 4a: channel 2 press then 8-cycle release
    do_reset(5'b00000, "t4a");
    for (int k = 1; k <= 8; k++)
      cyc(on(2, 1'b1), on(2, k >= 8), on(2, k == 8), 5'b0, "t4a press", k);
    for (int k = 1; k <= 10; k++)
      cyc(5'b0, on(2, k < 8), 5'b0, on(2, k == 8), "t4a release", k);

    // 4b: 7-cycle low glitch must not release
    do_reset(5'b00000, "t4b");
    for (int k = 1; k <= 8; k++)
      cyc(on(2, 1'b1), on(2, k >= 8), on(2, k == 8), 5'b0, "t4b press", k);
    for (int k = 1; k <= 7; k++)
      cyc(5'b0, on(2, 1'b1), 5'b0, 5'b0, "t4b glitch", k);
    for (int k = 1; k <= 4; k++)
      cyc(on(2, 1'b1), on(2, 1'b1), 5'b0, 5'b0, "t4b hold", k);

    // 5: reset mid-count aborts, then count restarts from zero
    do_reset(5'b00000, "t5");
    for (int k = 1; k <= 5; k++)
      cyc(on(3, 1'b1), 5'b0, 5'b0, 5'b0, "t5 pre", k);
    do_reset(on(3, 1'b1), "t5 mid");
    for (int k = 1; k <= 9; k++)
      cyc(on(3, 1'b1), on(3, k >= 8), on(3, k == 8), 5'b0, "t5 post", k);

    // 6: long hold on channel 4, release after 38 cycles
`ifdef AUTOREPEAT_EN
    rep_edges = '{8, 24, 28, 32, 36, 40, 44};
`else
    rep_edges = '{8};
`endif
    do_reset(5'b00000, "t6");
    for (int k = 1; k <= 48; k++) begin
      bit pr_exp;
      pr_exp = 1'b0;
      foreach (rep_edges[j]) if (rep_edges[j] == k) pr_exp = 1'b1;
      cyc(on(4, k <= 38), on(4, (k >= 8) && (k < 46)), on(4, pr_exp), on(4, k == 46),
          "t6", k);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_button_debouncer
`default_nettype wire
